// File: rtl/pool_pkg.sv
// pool_pkg: shared job modes, FSM state encodings and a constant clog2 helper
// for the pooling / argmax stream unit.
// Contents: MODE_* (2-bit job mode), state_e (ST_IDLE/ST_RUN/ST_DRAIN), clog2().
package pool_pkg;

  localparam logic [1:0] MODE_MAX    = 2'd0;
  localparam logic [1:0] MODE_AVG    = 2'd1;
  localparam logic [1:0] MODE_ARGMAX = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time constants; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_reducer.sv
// pool_reducer: combinational next-accumulator step for MAX / AVG / ARGMAX.
// Ports: mode_i, first_i (seed with data), acc_i/idx_i (current), data_i/pos_i (beat)
//        -> acc_o/idx_o (next). Zero latency, no handshake.
module pool_reducer
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int SUM_W  = 34
) (
  input  logic [1:0]              mode_i,
  input  logic                    first_i,
  input  logic signed [SUM_W-1:0] acc_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]        pos_i,
  output logic signed [SUM_W-1:0] acc_o,
  output logic [IDX_W-1:0]        idx_o
);

  logic signed [SUM_W-1:0] data_ext;

  // The accumulator is wider than the data so the AVG sum cannot overflow;
  // MAX/ARGMAX keep a sign-extended value in the same register.
  assign data_ext = {{(SUM_W-DATA_W){data_i[DATA_W-1]}}, data_i};

  always_comb begin
    acc_o = acc_i;
    idx_o = idx_i;
    if (mode_i == MODE_AVG) begin
      acc_o = first_i ? data_ext : acc_i + data_ext;
      idx_o = '0;
    end else if (first_i || (data_ext > acc_i)) begin
      // Strict greater-than: ties keep the earlier index.
      acc_o = data_ext;
      idx_o = (mode_i == MODE_ARGMAX) ? pos_i : '0;
    end
  end

endmodule

// File: rtl/pool_argmax_stream.sv
// pool_argmax_stream: per-window MAX/AVG or per-vector ARGMAX reduction of a signed stream.
// Ports: cfg_start/cfg_mode job setup; in_* valid/ready input; out_* registered result
//        (1 cycle after closing beat, held until out_ready); busy/done/err status.
//        in_ready drops while an unaccepted result is pending; no beat is lost.
module pool_argmax_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WIN    = 4,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [1:0]               cfg_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int LOG_WIN = clog2(WIN);
  localparam int SUM_W   = DATA_W + LOG_WIN;
  localparam logic [LOG_WIN-1:0] WCNT_LAST = LOG_WIN'(WIN - 1);
  localparam logic [IDX_W-1:0]   PCNT_LAST = '1;

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [LOG_WIN-1:0]      wcnt_q, wcnt_d;
  logic [IDX_W-1:0]        pcnt_q, pcnt_d;
  logic                    pfull_q, pfull_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]        out_idx_q, out_idx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    is_argmax;
  logic                    beat;
  logic                    close;
  logic                    first;
  logic signed [SUM_W-1:0] acc_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic signed [DATA_W-1:0] result;

  assign is_argmax = (mode_q == MODE_ARGMAX);
  assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign beat      = in_valid && in_ready;
  assign close     = beat && (in_last || (!is_argmax && (wcnt_q == WCNT_LAST)));
  // pcnt only returns to 0 at job start, so it marks the vector's first beat.
  assign first     = is_argmax ? ((pcnt_q == '0) && !pfull_q) : (wcnt_q == '0);

  pool_reducer #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .SUM_W  (SUM_W)
  ) u_reducer (
    .mode_i  (mode_q),
    .first_i (first),
    .acc_i   (acc_q),
    .idx_i   (best_idx_q),
    .data_i  (in_data),
    .pos_i   (pcnt_q),
    .acc_o   (acc_nxt),
    .idx_o   (idx_nxt)
  );

  // AVG: taking bits above LOG_WIN is an arithmetic shift, i.e. floor(sum / WIN),
  // and a short window still divides by WIN.
  assign result = (mode_q == MODE_AVG) ? acc_nxt[LOG_WIN +: DATA_W] : acc_nxt[DATA_W-1:0];

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    best_idx_d  = best_idx_q;
    wcnt_d      = wcnt_q;
    pcnt_d      = pcnt_q;
    pfull_d     = pfull_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_mode == MODE_RSVD) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            mode_d     = cfg_mode;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            acc_d      = '0;
            best_idx_d = '0;
            wcnt_d     = '0;
            pcnt_d     = '0;
            pfull_d    = 1'b0;
          end
        end
      end

      ST_RUN: begin
        if (beat) begin
          if (close) begin
            // Loading here overrides the clear above: a result can leave and
            // the next one arrive on the same edge.
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_idx_d   = is_argmax ? idx_nxt : '0;
            acc_d       = '0;
            best_idx_d  = '0;
            wcnt_d      = '0;
          end else begin
            acc_d      = acc_nxt;
            best_idx_d = idx_nxt;
            wcnt_d     = is_argmax ? '0 : wcnt_q + 1'b1;
          end
          if (is_argmax) begin
            // Past 2^IDX_W beats the position sticks at its maximum; such
            // beats still compete for the max but flag an error.
            if (pfull_q) err_d = 1'b1;
            if (pcnt_q == PCNT_LAST) pfull_d = 1'b1;
            else                     pcnt_d  = pcnt_q + 1'b1;
          end
          if (in_last) begin
            state_d = ST_DRAIN;
            pcnt_d  = '0;
            pfull_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_MAX;
      acc_q       <= '0;
      best_idx_q  <= '0;
      wcnt_q      <= '0;
      pcnt_q      <= '0;
      pfull_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      best_idx_q  <= best_idx_d;
      wcnt_q      <= wcnt_d;
      pcnt_q      <= pcnt_d;
      pfull_q     <= pfull_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pool_argmax_stream.sv
// tb_pool_argmax_stream: directed bench for pool_argmax_stream (DATA_W=32, WIN=4, IDX_W=4).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Results are collected by a handshake monitor and compared with hand-computed values.
module tb_pool_argmax_stream;
  import pool_pkg::*;

  localparam int DATA_W = 32;
  localparam int WIN    = 4;
  localparam int IDX_W  = 4;

  logic                     clk;
  logic                     rst;
  logic                     cfg_start;
  logic [1:0]               cfg_mode;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     busy;
  logic                     done;
  logic                     err;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  logic signed [DATA_W-1:0] res_q[$];
  logic [IDX_W-1:0]         idx_q[$];

  int v_max[8]  = '{-3, 7, 7, -10, 1, 2, 3, 4};
  int v_avg[6]  = '{-1, -2, -2, -2, 5, 6};
  int v_arg[10] = '{3, 9, -4, 9, 0, 1, 2, 8, 9, 5};

  pool_argmax_stream #(
    .DATA_W (DATA_W),
    .WIN    (WIN),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_mode  (cfg_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      res_q.push_back(out_data);
      idx_q.push_back(out_idx);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [1:0] m);
    cfg_start = 1'b1;
    cfg_mode  = m;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send(input int val, input bit last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = val;
    in_last  = last;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt);
    for (int c = 0; c < 50; c++) begin
      if (done_cnt >= exp_cnt) break;
      @(negedge clk);
    end
    check("done_count", done_cnt, exp_cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_mode  = MODE_MAX;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // MAX: two full windows streamed back to back
    res_q.delete(); idx_q.delete();
    start_job(MODE_MAX);
    check("max_busy", busy, 1);
    for (int i = 0; i < 8; i++) send(v_max[i], i == 7);
    wait_done(1);
    check("max_nres", res_q.size(), 2);
    if (res_q.size() == 2) begin
      check("max_res0", res_q[0], 7);
      check("max_res1", res_q[1], 4);
      check("max_idx0", idx_q[0], 0);
    end
    check("max_busy_end", busy, 0);

    // AVG: floor on negative sum, short window divides by WIN
    res_q.delete(); idx_q.delete();
    start_job(MODE_AVG);
    for (int i = 0; i < 6; i++) send(v_avg[i], i == 5);
    wait_done(2);
    check("avg_nres", res_q.size(), 2);
    if (res_q.size() == 2) begin
      check("avg_res0", res_q[0], -2);
      check("avg_res1", res_q[1], 2);
    end

    // ARGMAX: tie keeps earliest index
    res_q.delete(); idx_q.delete();
    start_job(MODE_ARGMAX);
    for (int i = 0; i < 10; i++) send(v_arg[i], i == 9);
    wait_done(3);
    check("arg_nres", res_q.size(), 1);
    if (res_q.size() == 1) begin
      check("arg_val", res_q[0], 9);
      check("arg_idx", idx_q[0], 1);
    end
    check("arg_err", err, 0);

    // Backpressure: first result held for 5 cycles with a beat waiting
    res_q.delete(); idx_q.delete();
    out_ready = 1'b0;
    start_job(MODE_MAX);
    send(10, 0); send(20, 0); send(5, 0); send(1, 0);
    in_valid = 1'b1;
    in_data  = 30;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 20);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(30, 0); send(-1, 0); send(-5, 0); send(2, 1);
    wait_done(4);
    check("bp_nres", res_q.size(), 2);
    if (res_q.size() == 2) begin
      check("bp_res0", res_q[0], 20);
      check("bp_res1", res_q[1], 30);
    end

    // ARGMAX overflow: 17 beats, max on the last one
    res_q.delete(); idx_q.delete();
    start_job(MODE_ARGMAX);
    for (int i = 0; i < 17; i++) send((i == 16) ? 50 : 1, i == 16);
    wait_done(5);
    check("ovf_nres", res_q.size(), 1);
    if (res_q.size() == 1) begin
      check("ovf_val", res_q[0], 50);
      check("ovf_idx", idx_q[0], 15);
    end
    check("ovf_err", err, 1);

    // cfg_start clears err
    res_q.delete(); idx_q.delete();
    start_job(MODE_MAX);
    check("clr_err", err, 0);
    send(5, 1);
    wait_done(6);
    check("clr_res", (res_q.size() == 1) ? res_q[0] : -999, 5);

    // Reserved mode stays idle and flags err
    start_job(MODE_RSVD);
    check("rsvd_err", err, 1);
    check("rsvd_busy", busy, 0);

    // cfg_start while running is ignored, then reset mid AVG window
    start_job(MODE_AVG);
    check("avg2_err_clr", err, 0);
    start_job(MODE_RSVD);
    check("ign_err", err, 0);
    check("ign_busy", busy, 1);
    send(100, 0); send(200, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    res_q.delete(); idx_q.delete();
    start_job(MODE_AVG);
    for (int i = 0; i < 4; i++) send(4, i == 3);
    wait_done(7);
    check("post_rst_nres", res_q.size(), 1);
    if (res_q.size() == 1) check("post_rst_res", res_q[0], 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pool_argmax_stream.md
# pool_argmax_stream

Streaming reduction unit for the accelerator's output path. It is the parametrised successor to the fixed max-pool/softmax stage. It consumes signed psum-width words from the ofmap read mux over a valid/ready handshake. It emits one result per pooling window in MAX or AVG mode, or one (max value, index) pair per vector in ARGMAX mode, which produces the class prediction. It sits between the ofmap1/ofmap2 read mux and the ofmap write mux, and is configured per job by the controller.

## Interface
- DATA_W, 32: signed data width, equal to the psum width.
- WIN, 4: elements per pooling window. Must be a power of two, 2..16.
- IDX_W, 4: argmax index width. The maximum vector length is 2^IDX_W.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse that starts a job. Honoured only in IDLE.
- cfg_mode  in  2  job mode: 0 MAX, 1 AVG, 2 ARGMAX. 3 is reserved.
- in_valid  in  1  input word valid.
- in_ready  out  1  input accepted this cycle when in_valid is also high.
- in_data  in  DATA_W  signed input word.
- in_last  in  1  marks the final word of the job.
- out_valid  out  1  result valid. Held until accepted.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  signed result.
- out_idx  out  IDX_W  argmax index. 0 in MAX/AVG.
- busy  out  1  high from cfg_start accept until done.
- done  out  1  one-cycle pulse after the final result is accepted.
- err  out  1  sticky error flag. Cleared by cfg_start.

## Operation
- States:
  - IDLE goes to RUN on cfg_start. cfg_mode is latched at that point; reserved mode 3 sets err and stays in IDLE.
  - RUN goes to DRAIN when the beat carrying in_last is accepted.
  - DRAIN goes to IDLE when the final output handshake completes, and pulses done in the same transition.
- A beat is accepted when in_valid and in_ready are both high. in_ready = (state == RUN) && (!out_valid || out_ready). It is 0 in IDLE and DRAIN.
- Window counter wcnt runs from 0 to WIN-1 in MAX/AVG mode.
  - On accepting the beat at wcnt == WIN-1, or any beat with in_last, the window result is loaded into the output register and the accumulator restarts.
- MAX mode:
  - Signed compare. The first element seeds the accumulator.
  - A partial window (in_last early) yields the max over the received elements.
- AVG mode:
  - The sum is held at DATA_W + log2(WIN) bits and arithmetically shifted right by log2(WIN), which floors the result.
  - A partial window divides by WIN anyway; missing elements count as 0.
- ARGMAX mode:
  - One vector per job, ending at in_last, and a single output.
  - Strict greater-than update, so a tie keeps the earliest index.
  - Beat position counter pcnt runs from 0.
  - Beyond 2^IDX_W beats, err is set, pcnt saturates and those beats still participate in the value compare.
- A cfg_start pulse outside IDLE is ignored and does not set err.
- Reset: state IDLE. out_valid, out_data, out_idx, busy, done, err, the counters and the accumulator all go to 0. in_ready is 0.
- Reset mid-job abandons the job; no done pulse is issued.

## Timing
- Latency: out_valid rises in the cycle after the window-closing (or in_last) beat is accepted.
- Throughput: one beat per cycle with out_ready held high.
  - A window's result is emitted while the next window's first beat is being accepted, with no bubble.
- Backpressure:
  - With out_valid high and out_ready low, in_ready drops. out_data and out_idx stay stable.
  - While stalled, the accumulator holds its contents and no beat is lost.
- done pulses in the cycle after the final out_valid && out_ready handshake. busy falls in that same cycle.
- A cfg_start in the cycle done is high is honoured, because state is already IDLE.

## Structure
- Package pool_pkg holds:
  - the mode localparams MODE_MAX, MODE_AVG, MODE_ARGMAX;
  - the state encodings ST_IDLE, ST_RUN, ST_DRAIN;
  - a clog2 function.
- One sub-module, pool_reducer: the combinational compare/add for the next accumulator value and the argmax index update, parametrised by DATA_W and IDX_W.
- The top level holds the FSM, the counters, the output register and the handshake.

## Test plan
- MAX, WIN=4, inputs -3, 7, 7, -10, then 1, 2, 3, 4 with in_last on the 8th -> outputs 7 then 4, then a done pulse.
- AVG, WIN=4, inputs -1, -2, -2, -2 -> sum -7, out_data -2 (floor). Inputs 5, 6 with in_last on the 2nd -> out_data 2 (11 >> 2).
- ARGMAX, 10 beats 3, 9, -4, 9, 0, 1, 2, 8, 9, 5 -> out_data 9, out_idx 1.
- Backpressure: MAX with out_ready low for 5 cycles after the first result -> in_ready 0 for those cycles, out_data stable, second result correct once out_ready is released.
- ARGMAX with 17 beats at IDX_W=4 -> err=1, out_idx saturates at 15 if the max arrives late. A subsequent cfg_start clears err.
- Assert rst mid-window in AVG mode -> all outputs 0 immediately. A new job afterwards is unaffected by the stale sum.
